// File: rtl/log2_seq_pkg.sv
// Shared types and width helpers for the sequential base-2 logarithm.
// Optional feature macro: LOG2_SEQ_ROUND_EN (round-half-up of the fraction).
package log2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } state_t;

  // Integer-part width needed to hold a bit index of a width-bit operand.
  function automatic int int_w(input int width);
    return $clog2(width);
  endfunction

  // Result width: integer part followed by frac fraction bits.
  function automatic int out_w(input int width, input int frac);
    return $clog2(width) + frac;
  endfunction

endpackage

// File: rtl/log2_seq_if.sv
// Operand/result handshake bundle for log2_seq.
// The master side presents operands and consumes results; the slave is the log2 engine.
interface log2_seq_if
  import log2_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 8
) ();

  localparam int OUT_W = out_w(WIDTH, FRAC_BITS);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out0;
  logic             zero_err;

  modport master (
    output in_valid, in0, out_ready,
    input  in_ready, out_valid, out0, zero_err
  );

  modport slave (
    input  in_valid, in0, out_ready,
    output in_ready, out_valid, out0, zero_err
  );

endinterface

// File: rtl/log2_lod.sv
// Leading-one detector: index of the most significant set bit plus an all-zero flag.
// Purely combinational; an all-zero input reports index 0.
module log2_lod #(
  parameter int WIDTH = 32,
  parameter int INT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_s,
  output logic [INT_W-1:0] msb_idx_s,
  output logic             is_zero_s
);

  // Scan upward so the highest set bit wins the last assignment.
  always_comb begin
    msb_idx_s = {INT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_s[i]) begin
        msb_idx_s = INT_W'(i);
      end else begin
        msb_idx_s = msb_idx_s;
      end
    end
  end

  assign is_zero_s = ~|vec_s;

endmodule

// File: rtl/log2_seq.sv
// Sequential fixed-point log2: integer part from the leading-one position, fraction
// bits from repeated squaring of the normalised mantissa, one bit per clock.
// Optional feature macro: LOG2_SEQ_ROUND_EN adds one iteration and rounds half-up,
// saturating the fraction at all-ones instead of carrying into the integer part.
module log2_seq
  import log2_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 8
) (
  input logic       clk,
  input logic       rst,
  log2_seq_if.slave bus
);

  localparam int INT_W = int_w(WIDTH);
  localparam int OUT_W = out_w(WIDTH, FRAC_BITS);
`ifdef LOG2_SEQ_ROUND_EN
  localparam int ITERS = FRAC_BITS + 1;
`else
  localparam int ITERS = FRAC_BITS;
`endif
  localparam int CNT_W = $clog2(ITERS + 1);

  state_t             state_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               zero_err_r;
  logic [OUT_W-1:0]   out0_r;
  logic [WIDTH-1:0]   op_r;
  logic [WIDTH-1:0]   m_r;
  logic [INT_W-1:0]   k_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ITERS-1:0]   frac_sr_r;

  logic [INT_W-1:0]   lod_idx_s;
  logic               lod_zero_s;
  logic [INT_W-1:0]   shamt_s;
  logic [WIDTH-1:0]   norm_s;
  logic [2*WIDTH-1:0] sq_s;
  logic [WIDTH:0]     sq_hi_s;
  logic               bit_s;
  logic [WIDTH-1:0]   m_next_s;
  logic [FRAC_BITS-1:0] frac_s;

  log2_lod #(.WIDTH(WIDTH), .INT_W(INT_W)) u_lod (
    .vec_s     (op_r),
    .msb_idx_s (lod_idx_s),
    .is_zero_s (lod_zero_s)
  );

  // Normalise the captured operand so its leading one sits in the MSB (1.(W-1) format).
  always_comb begin
    shamt_s = INT_W'(WIDTH - 1) - lod_idx_s;
    norm_s  = op_r << shamt_s;
  end

  // Square the mantissa; keep the top W+1 bits, then renormalise by one position
  // when the square reached [2,4), which is exactly when the next fraction bit is 1.
  always_comb begin
    sq_s     = {{WIDTH{1'b0}}, m_r} * {{WIDTH{1'b0}}, m_r};
    sq_hi_s  = (WIDTH + 1)'(sq_s >> (WIDTH - 1));
    bit_s    = sq_hi_s[WIDTH];
    if (bit_s) begin
      m_next_s = sq_hi_s[WIDTH:1];
    end else begin
      m_next_s = sq_hi_s[WIDTH-1:0];
    end
  end

  // Final fraction: raw bits, or rounded on the guard bit with saturation at all-ones.
  always_comb begin
    frac_s = {FRAC_BITS{1'b0}};
`ifdef LOG2_SEQ_ROUND_EN
    if (&frac_sr_r[ITERS-1:1]) begin
      frac_s = frac_sr_r[ITERS-1:1];
    end else begin
      frac_s = frac_sr_r[ITERS-1:1] + FRAC_BITS'(frac_sr_r[0]);
    end
`else
    frac_s = frac_sr_r;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      zero_err_r  <= 1'b0;
      out0_r      <= {OUT_W{1'b0}};
      op_r        <= {WIDTH{1'b0}};
      m_r         <= {WIDTH{1'b0}};
      k_r         <= {INT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      frac_sr_r   <= {ITERS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_r       <= bus.in0;
            in_ready_r <= 1'b0;
            state_r    <= NORM;
          end else begin
            state_r    <= IDLE;
          end
        end
        NORM: begin
          k_r       <= lod_idx_s;
          m_r       <= norm_s;
          cnt_r     <= CNT_W'(ITERS);
          frac_sr_r <= {ITERS{1'b0}};
          if (lod_zero_s) begin
            out0_r      <= {OUT_W{1'b0}};
            zero_err_r  <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= FRAC;
          end
        end
        FRAC: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            m_r       <= m_next_s;
            frac_sr_r <= (frac_sr_r << 1'b1) | ITERS'(bit_s);
            cnt_r     <= cnt_r - CNT_W'(1);
          end else begin
            out0_r      <= {k_r, frac_s};
            zero_err_r  <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out0      = out0_r;
  assign bus.zero_err  = zero_err_r;

endmodule

// File: tb/tb_log2_seq.sv
// Self-checking bench for log2_seq: directed corner operands, abort by reset,
// then randomised operands against an arithmetic reference model.
module tb_log2_seq;
  import log2_seq_pkg::*;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 8;
`ifdef LOG2_SEQ_ROUND_EN
  localparam int LAT = FRAC_BITS + 3;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = FRAC_BITS + 2;
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  log2_seq_if #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) bus ();

  log2_seq #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer part = floor(log2 x); fraction bits from repeated squaring of
  // x/2^k in [1,2): a square >= 2 yields a 1 and is halved.
  function automatic void ref_log2(input logic [31:0] x, output logic [31:0] r, output logic z);
    longint unsigned m;
    longint unsigned s;
    longint unsigned acc;
    longint unsigned fr;
    int k;
    int nb;
    r = 32'd0;
    z = 1'b0;
    if (x == 32'd0) begin
      z = 1'b1;
      return;
    end
    k = 0;
    for (int i = 0; i < 32; i++) if (x[i]) k = i;
    m = 64'(x);
    m = m << (31 - k);
    nb = RND ? FRAC_BITS + 1 : FRAC_BITS;
    acc = 64'd0;
    for (int i = 0; i < nb; i++) begin
      s = m * m;
      if (s[63]) begin
        acc = acc * 2 + 1;
        m = s >> 32;
      end else begin
        acc = acc * 2;
        m = (s >> 31) & 64'hFFFF_FFFF;
      end
    end
    if (RND) begin
      fr = acc >> 1;
      if (acc[0] && fr != 64'((1 << FRAC_BITS) - 1)) fr = fr + 1;
    end else begin
      fr = acc;
    end
    r = 32'(k * (1 << FRAC_BITS)) + 32'(fr);
  endfunction

  // One transaction: wait for idle, present x, wait for the result, hold it for
  // 'stall' cycles, then retire it while a stray operand is offered.
  task automatic run_op(input logic [31:0] x, input logic [31:0] exp, input logic ez,
                        input int stall, input bit chk_lat);
    int cyc;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.in0      = x;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in0      = $urandom;
    check_eq("busy_after_accept", 32'(bus.in_ready), 32'd0);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (chk_lat) check_eq("latency", 32'(cyc), 32'(LAT));
    else         check_eq("valid_seen", 32'(bus.out_valid), 32'd1);
    check_eq("out0", 32'(bus.out0), exp);
    check_eq("zero_err", 32'(bus.zero_err), 32'(ez));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_out0", 32'(bus.out0), exp);
      check_eq("hold_zero_err", 32'(bus.zero_err), 32'(ez));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in0       = $urandom;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("retired", 32'(bus.out_valid), 32'd0);
    check_eq("no_accept_on_retire", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    logic        ez;
    logic [31:0] x;
    int          seen;

    bus.in_valid  = 1'b0;
    bus.in0       = 32'd0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out0", 32'(bus.out0), 32'd0);
    check_eq("rst_zero_err", 32'(bus.zero_err), 32'd0);

    // Directed corner operands with hand-computed results.
    run_op(32'd1, 32'h000, 1'b0, 0, 1'b1);
    run_op(32'd8, 32'h300, 1'b0, 1, 1'b1);
    run_op(32'h8000_0000, 32'h1F00, 1'b0, 0, 1'b1);
    run_op(32'd3, RND ? 32'h196 : 32'h195, 1'b0, 2, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h1FFF, 1'b0, 0, 1'b1);
    run_op(32'd0, 32'h000, 1'b1, 5, 1'b0);

    // Reset during the fraction iterations discards the calculation.
    bus.in0      = 32'd12345;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_out0", 32'(bus.out0), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check_eq("abort_no_result", 32'(seen), 32'd0);

    // Randomised operands spread over all magnitudes, with random consumer stalls.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0:       x = 32'd0;
        1, 2:    x = $urandom_range(1, 16);
        default: x = $urandom >> $urandom_range(0, 31);
      endcase
      ref_log2(x, exp, ez);
      run_op(x, exp, ez, $urandom_range(0, 3), (x != 32'd0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
